dbus_arbiter: RTL

- Shares the single data-memory/UART bus between two requesters:
  - m0: RISC-V core data port.
  - m1: UART bootloader / DMA engine.
- Round-robin arbitration with an optional bus lock.
- Decodes each granted beat into the RAM write enable and the UART read/write strobes.
- Sits between the requesters and the data_memory / chu_uart instances at MCU top level.

---
 rtl/mcu_bus_pkg.sv | 23 ++
 rtl/dbus_addr_decode.sv | 26 ++
 rtl/dbus_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mcu_bus_pkg.sv
// Shared MCU data-bus definitions: arbiter states, owner encoding and the UART register window.
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  // UART register window; the first address is status/RX-pop, the rest are writable.
  localparam logic [31:0] UART_BASE_ADDR = 32'h0000_0500;
  localparam logic [31:0] UART_LAST_ADDR = 32'h0000_0503;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_M0) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational beat decode into RAM write / UART write / UART read strobes; zero latency, no flow control.
module dbus_addr_decode
  import mcu_bus_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] UART_BASE = WIDTH'(UART_BASE_ADDR),
  parameter logic [WIDTH-1:0] UART_LAST = WIDTH'(UART_LAST_ADDR)
) (
  input  logic [WIDTH-1:0] addr_i,
  input  logic             we_i,
  output logic             uart_hit_o,
  output logic             ram_we_o,
  output logic             uart_wen_o,
  output logic             uart_ren_o
);

  logic at_base;

  assign at_base    = (addr_i == UART_BASE);
  assign uart_hit_o = (addr_i >= UART_BASE) && (addr_i <= UART_LAST);
  assign ram_we_o   = we_i & ~uart_hit_o;
  // The base register is read-only status; a write there is acked but strobes nothing.
  assign uart_wen_o = we_i & uart_hit_o & ~at_base;
  assign uart_ren_o = ~we_i & at_base;

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master round-robin data-bus arbiter with lock; beat = IDLE->ACCESS->RESP (3 cycles), req held until ack.
// Optional lock watchdog enabled by DBUS_ARB_WATCHDOG_EN; otherwise lock_err is tied low.
module dbus_arbiter
  import mcu_bus_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] UART_BASE = WIDTH'(UART_BASE_ADDR),
  parameter logic [WIDTH-1:0] UART_LAST = WIDTH'(UART_LAST_ADDR),
  parameter int unsigned      LOCK_MAX  = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic             m0_lock,
  output logic             m0_gnt,
  output logic             m0_ack,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic             m1_lock,
  output logic             m1_gnt,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [WIDTH-1:0] s_addr,
  output logic [WIDTH-1:0] s_wdata,
  output logic             s_ram_we,
  output logic             s_uart_wen,
  output logic             s_uart_ren,
  input  logic [WIDTH-1:0] s_ram_rdata,
  input  logic [WIDTH-1:0] s_uart_rdata,
  output logic             lock_err
);

  bus_state_e       state_q;
  owner_e           owner_q, last_owner_q;
  logic             lock_held_q;
  logic             m0_gnt_q, m1_gnt_q, m0_ack_q, m1_ack_q;
  logic [WIDTH-1:0] m0_rdata_q, m1_rdata_q, s_addr_q, s_wdata_q;
  logic             s_ram_we_q, s_uart_wen_q, s_uart_ren_q, uart_hit_q;

  logic             own_lock, lock_active, wd_trip;
  logic             win_vld, win_we;
  owner_e           win;
  logic [WIDTH-1:0] win_addr, win_wdata, rdata_sel;
  logic             dec_hit, dec_ram_we, dec_uart_wen, dec_uart_ren;

  assign own_lock    = (owner_q == OWN_M1) ? m1_lock : m0_lock;
  // A dropped lock or a watchdog trip frees arbitration in the same IDLE cycle.
  assign lock_active = lock_held_q & own_lock & ~wd_trip;

  always_comb begin
    win_vld = 1'b0;
    win     = owner_q;
    if (lock_active) begin
      win_vld = (owner_q == OWN_M1) ? m1_req : m0_req;
    end else if (m0_req && m1_req) begin
      win_vld = 1'b1;
      win     = other_owner(last_owner_q);
    end else if (m0_req) begin
      win_vld = 1'b1;
      win     = OWN_M0;
    end else if (m1_req) begin
      win_vld = 1'b1;
      win     = OWN_M1;
    end
  end

  assign win_we    = (win == OWN_M1) ? m1_we    : m0_we;
  assign win_addr  = (win == OWN_M1) ? m1_addr  : m0_addr;
  assign win_wdata = (win == OWN_M1) ? m1_wdata : m0_wdata;
  assign rdata_sel = uart_hit_q ? s_uart_rdata : s_ram_rdata;

  dbus_addr_decode #(
    .WIDTH     (WIDTH),
    .UART_BASE (UART_BASE),
    .UART_LAST (UART_LAST)
  ) u_decode (
    .addr_i     (win_addr),
    .we_i       (win_we),
    .uart_hit_o (dec_hit),
    .ram_we_o   (dec_ram_we),
    .uart_wen_o (dec_uart_wen),
    .uart_ren_o (dec_uart_ren)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_M0;
      last_owner_q <= OWN_M1;
      lock_held_q  <= 1'b0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_ram_we_q   <= 1'b0;
      s_uart_wen_q <= 1'b0;
      s_uart_ren_q <= 1'b0;
      uart_hit_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!own_lock || wd_trip) lock_held_q <= 1'b0;
          if (win_vld) begin
            state_q      <= ACCESS;
            owner_q      <= win;
            last_owner_q <= win;
            m0_gnt_q     <= (win == OWN_M0);
            m1_gnt_q     <= (win == OWN_M1);
            s_addr_q     <= win_addr;
            s_wdata_q    <= win_wdata;
            s_ram_we_q   <= dec_ram_we;
            s_uart_wen_q <= dec_uart_wen;
            s_uart_ren_q <= dec_uart_ren;
            uart_hit_q   <= dec_hit;
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          lock_held_q  <= own_lock & ~wd_trip;
          m0_gnt_q     <= 1'b0;
          m1_gnt_q     <= 1'b0;
          s_addr_q     <= '0;
          s_wdata_q    <= '0;
          s_ram_we_q   <= 1'b0;
          s_uart_wen_q <= 1'b0;
          s_uart_ren_q <= 1'b0;
          m0_ack_q     <= (owner_q == OWN_M0);
          m1_ack_q     <= (owner_q == OWN_M1);
          m0_rdata_q   <= (owner_q == OWN_M0) ? rdata_sel : '0;
          m1_rdata_q   <= (owner_q == OWN_M1) ? rdata_sel : '0;
        end
        default: begin
          state_q    <= IDLE;
          if (wd_trip) lock_held_q <= 1'b0;
          m0_ack_q   <= 1'b0;
          m1_ack_q   <= 1'b0;
          m0_rdata_q <= '0;
          m1_rdata_q <= '0;
        end
      endcase
    end
  end

`ifdef DBUS_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             lock_err_q, oth_req, wd_count;

  assign oth_req  = (owner_q == OWN_M1) ? m0_req : m1_req;
  assign wd_count = lock_held_q & oth_req;
  // Trips on the cycle the starvation count reaches LOCK_MAX.
  assign wd_trip  = wd_count & (wd_cnt_q == CNT_W'(LOCK_MAX - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_q   <= '0;
      lock_err_q <= 1'b0;
    end else if (wd_trip) begin
      wd_cnt_q   <= '0;
      lock_err_q <= 1'b1;
    end else if (wd_count) begin
      wd_cnt_q   <= wd_cnt_q + 1'b1;
    end else begin
      wd_cnt_q   <= '0;
    end
  end

  assign lock_err = lock_err_q;
`else
  assign wd_trip  = 1'b0;
  assign lock_err = 1'b0;
`endif

  assign m0_gnt     = m0_gnt_q;
  assign m1_gnt     = m1_gnt_q;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign s_addr     = s_addr_q;
  assign s_wdata    = s_wdata_q;
  assign s_ram_we   = s_ram_we_q;
  assign s_uart_wen = s_uart_wen_q;
  assign s_uart_ren = s_uart_ren_q;

endmodule
